out_uart_bridge: RTL and testbench

//   Downstream consumer of the stack CPU OUT instruction (LEDS byte + Lr strobe).
//   - Mirrors each output byte onto the board LEDs.
//   - Queues the byte in a small FIFO and serialises it on an 8N1 UART TX line,
//     so program output reaches a host without stalling the CPU.

---
 rtl/out_uart_bridge_pkg.sv | 15 +
 rtl/out_uart_bridge_byte_fifo.sv | 52 +++++
 rtl/out_uart_bridge.sv | 188 ++++++++++++++++++
 tb/tb_out_uart_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_uart_bridge_pkg.sv
// Shared types and defaults for the OUT-instruction UART bridge.
package out_uart_bridge_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_FIFO_AW      = 3;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/out_uart_bridge_byte_fifo.sv
// Byte-wide circular FIFO with separate occupancy count; depth 2**FIFO_AW.
module out_uart_bridge_byte_fifo
  import out_uart_bridge_pkg::*;
#(
  parameter int FIFO_AW = DEFAULT_FIFO_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [7:0]         din_i,
  output logic [7:0]         dout_o,
  output logic [FIFO_AW:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Read is combinational, so a pop with a push on a full FIFO still sees the old head.
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = count_q[FIFO_AW];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/out_uart_bridge.sv
// CPU OUT-port consumer: mirrors bytes to LEDs and streams them out a UART.
// Define OUT_UART_PARITY_EN for 8E1 frames; the default build sends 8N1.
module out_uart_bridge
  import out_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = DEFAULT_FIFO_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       out_data,
  input  logic             out_strobe,
  output logic [7:0]       leds,
  output logic             tx,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic            strobe_q;
  logic [7:0]      leds_q;
  logic            overflow_q;
  logic            cap;
  logic            push;
  logic            pop;

  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            bit_done;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
`ifdef OUT_UART_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Rising-edge capture: a strobe held for many cycles counts once.
  assign cap  = out_strobe & ~strobe_q;
  assign push = cap & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q   <= 1'b0;
      leds_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q <= out_strobe;
      if (cap)         leds_q     <= out_data;
      if (cap && !push) overflow_q <= 1'b1;
    end
  end

  out_uart_bridge_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (out_data),
    .dout_o  (fifo_dout),
    .count_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_done = (baud_q == BAUD_LAST);

  // NOTE: sequential state uses non-blocking assignment only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef OUT_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef OUT_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef OUT_UART_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          state_d = TX_START;
          shift_d = fifo_dout;
          baud_d  = '0;
`ifdef OUT_UART_PARITY_EN
          parity_d = ^fifo_dout;
`endif
        end
      end
      TX_START: begin
        if (bit_done) begin
          state_d   = TX_DATA;
          baud_d    = '0;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef OUT_UART_PARITY_EN
      TX_PARITY: begin
        if (bit_done) begin
          state_d = TX_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_done) begin
          state_d = TX_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level and busy are registered one cycle behind the state, keeping tx glitch-free.
  always_comb begin
    pop    = 1'b0;
    tx_d   = 1'b1;
    busy_d = (state_q != TX_IDLE);
    case (state_q)
      TX_IDLE:   pop  = !fifo_empty;
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_q[0];
`ifdef OUT_UART_PARITY_EN
      TX_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign leds     = leds_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_out_uart_bridge.sv
// Self-checking bench for out_uart_bridge: queue-based reference model plus directed scenarios.
module tb_out_uart_bridge;

  localparam int CPB   = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef OUT_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    out_data = 8'h00;
  logic          out_strobe = 1'b0;
  logic [7:0]    leds;
  logic          tx;
  logic          tx_busy;
  logic [AW:0]   fifo_level;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  out_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .leds       (leds),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue plus a frame timer counted in edges since the pop.
  byte unsigned          m_q[$];
  logic [7:0]            m_leds = 8'h00;
  logic                  m_ovf = 1'b0;
  logic                  m_prev = 1'b0;
  logic                  m_active = 1'b0;
  logic                  m_valid = 1'b0;
  int                    m_age = 0;
  logic [FRAME_BITS-1:0] m_bits = '1;

  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
`ifdef OUT_UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  always @(posedge clk) begin
    logic do_pop, do_cap;
    int   lvl;
    if (!rst_n) begin
      m_q.delete();
      m_leds = 8'h00; m_ovf = 1'b0; m_prev = 1'b0;
      m_active = 1'b0; m_age = 0; m_valid = 1'b1;
    end else begin
      if (m_active) begin
        m_age++;
        if (m_age > FRAME_CYC) m_active = 1'b0;
      end
      lvl    = m_q.size();
      do_pop = !m_active && lvl > 0;
      do_cap = out_strobe && !m_prev;
      m_prev = out_strobe;
      if (do_pop) begin
        m_bits   = frame_of(m_q.pop_front());
        m_active = 1'b1;
        m_age    = 0;
      end
      if (do_cap) begin
        m_leds = out_data;
        if (lvl < DEPTH || do_pop) m_q.push_back(out_data);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_busy, exp_tx;
    if (m_valid) begin
      exp_busy = m_active && m_age >= 1;
      exp_tx   = exp_busy ? m_bits[(m_age - 1) / CPB] : 1'b1;
      check("leds", leds, m_leds);
      check("tx", tx, exp_tx);
      check("tx_busy", tx_busy, exp_busy);
      check("fifo_level", fifo_level, m_q.size());
      check("overflow", overflow, m_ovf);
    end
  end

  // Independent UART receiver, mid-bit sampling.
  byte unsigned rx_q[$];
  int           rx_c = -1;
  logic [7:0]   rx_b = 8'h00;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) rx_c = -1;
    else if (rx_c < 0) begin
      if (tx === 1'b0) rx_c = 0;
    end else begin
      rx_c++;
      if (rx_c % CPB == CPB / 2) begin
        int k;
        k = rx_c / CPB;
        if (k == 0) check("rx_start_bit", tx, 1'b0);
        else if (k <= 8) rx_b[k-1] = tx;
`ifdef OUT_UART_PARITY_EN
        else if (k == 9) check("rx_parity", tx, ^rx_b);
`endif
        else begin
          check("rx_stop_bit", tx, 1'b1);
          rx_q.push_back(rx_b);
          rx_c = -1;
        end
      end
    end
  end

  int busy_run = 0;
  int last_run = 0;
  int max_lvl  = 0;
  always @(negedge clk) begin
    if (tx_busy === 1'b1) busy_run++;
    else begin
      if (busy_run > 0) last_run = busy_run;
      busy_run = 0;
    end
    if (m_valid && fifo_level > max_lvl) max_lvl = fifo_level;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [7:0] d, input int hold);
    tick();
    out_data   = d;
    out_strobe = 1'b1;
    repeat (hold) tick();
    out_strobe = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (4) tick();
    while ((tx_busy !== 1'b0 || m_active || m_q.size() != 0 || rx_c >= 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < budget, 1'b1);
    repeat (4) tick();
  endtask

  int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int e;

  initial begin
    // 1: reset held three cycles
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_leds", leds, 8'h00);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 2: single 1-cycle strobe of A5, bit-exact waveform
    rx_q.delete();
    tick();
    out_data = 8'hA5; out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    @(negedge clk);
    check("t2_leds", leds, 8'hA5);
    check("t2_level_after_cap", fifo_level, 1);
    check("t2_tx_at_e", tx, 1'b1);
    tick(); @(negedge clk);
    check("t2_tx_at_e1", tx, 1'b1);
    check("t2_level_after_pop", fifo_level, 0);
    tick(); @(negedge clk);
    check("t2_start_bit", tx, 1'b0);
    check("t2_busy_on", tx_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick(); @(negedge clk);
      check("t2_data_bit", tx, a5_bits[i]);
    end
`ifdef OUT_UART_PARITY_EN
    repeat (CPB) tick(); @(negedge clk);
    check("t2_parity_bit", tx, 1'b0);
`endif
    repeat (CPB) tick(); @(negedge clk);
    check("t2_stop_bit", tx, 1'b1);
    wait_idle(4 * FRAME_CYC);
    check("t2_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t2_byte", rx_q[0], 8'hA5);
    check("t2_busy_len", last_run, FRAME_CYC);

    // 3: strobe held ten cycles captures once
    rx_q.delete(); max_lvl = 0;
    pulse(8'h3C, 10);
    wait_idle(4 * FRAME_CYC);
    check("t3_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t3_byte", rx_q[0], 8'h3C);
    check("t3_peak_level", max_lvl, 1);

    // 4: ten back-to-back strobes overflow the FIFO
    rx_q.delete(); max_lvl = 0;
    for (int i = 1; i <= 10; i++) pulse(8'(i), 1);
    @(negedge clk);
    check("t4_leds", leds, 8'h0A);
    check("t4_overflow", overflow, 1'b1);
    check("t4_peak_level", max_lvl, 8);
    wait_idle(12 * FRAME_CYC);
    check("t4_frames", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) check("t4_byte", rx_q[i], 8'(i + 1));

    // 5: push on the exact pop cycle of a full FIFO
    do_reset();
    rx_q.delete();
    tick();
    out_data = 8'h11; out_strobe = 1'b1;
    e = cyc + 1;
    tick();
    out_strobe = 1'b0;
    for (int j = 0; j < 8; j++) pulse(8'(8'h21 + j), 1);
    while (cyc < e + FRAME_CYC + 1) tick();
    check("t5_full_before", fifo_level, 8);
    out_data = 8'h99; out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    @(negedge clk);
    check("t5_level_kept", fifo_level, 8);
    check("t5_no_overflow", overflow, 1'b0);
    check("t5_leds", leds, 8'h99);
    wait_idle(12 * FRAME_CYC);
    check("t5_frames", rx_q.size(), 10);
    if (rx_q.size() == 10) begin
      check("t5_first", rx_q[0], 8'h11);
      for (int j = 0; j < 8; j++) check("t5_mid", rx_q[j+1], 8'(8'h21 + j));
      check("t5_last", rx_q[9], 8'h99);
    end

    // 6: reset in the middle of a frame
    rx_q.delete();
    tick();
    out_data = 8'hFF; out_strobe = 1'b1;
    e = cyc + 1;
    tick();
    out_strobe = 1'b0;
    while (cyc < e + 60) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_tx_after_rst", tx, 1'b1);
    check("t6_level_after_rst", fifo_level, 0);
    check("t6_busy_after_rst", tx_busy, 1'b0);
    repeat (2 * FRAME_CYC) tick();
    check("t6_no_frames", rx_q.size(), 0);
    pulse(8'h5A, 1);
    wait_idle(4 * FRAME_CYC);
    check("t6_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t6_byte", rx_q[0], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
